// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared types and helpers for the Hamming(16,11) SECDED decoder.
//   state_t      : decoder FSM states
//   flag_t       : 2-bit per-word error flag written with each decoded message
//   *_POS        : bit positions of the parity bits inside an encoded word
//   extract_data : pulls the 11 message bits out of an encoded word
// -----------------------------------------------------------------------------
package hamming_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        DECODE,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        FLG_NONE   = 2'b00,
        FLG_SINGLE = 2'b01,
        FLG_DOUBLE = 2'b10
    } flag_t;

    // Bit index equals Hamming position; P0 is the overall parity bit.
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    // Layout {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}: skip the parity slots.
    function automatic logic [10:0] extract_data(input logic [15:0] word);
        return {word[15:P8_POS+1], word[P8_POS-1:P4_POS+1], word[P4_POS-1]};
    endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder_if
// Start/done handshake, byte-wide memory port and error statistics.
//   req       : start request (driven by the requester)
//   done      : job complete, level
//   mem_addr  : byte address, AW bits
//   mem_rdata : read data, combinational from mem_addr
//   mem_wdata : write data
//   mem_we    : write strobe, memory writes on the rising edge where it is high
//   err1_cnt  : corrected single-error words in the last job
//   err2_cnt  : detected double-error words in the last job
// master = decoder side, slave = requester / memory side.
// -----------------------------------------------------------------------------
interface hamming_secded_decoder_if #(
    parameter int AW = 8
);
    logic          req;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [3:0]    err1_cnt;
    logic [3:0]    err2_cnt;

    modport master (
        input  req, mem_rdata,
        output done, mem_addr, mem_wdata, mem_we, err1_cnt, err2_cnt
    );

    modport slave (
        output req, mem_rdata,
        input  done, mem_addr, mem_wdata, mem_we, err1_cnt, err2_cnt
    );
endinterface

// File: rtl/secded_decode_core.sv
// -----------------------------------------------------------------------------
// secded_decode_core
// Combinational Hamming(16,11) SECDED decode of one word.
//   word     : 16-bit encoded word (bit index == Hamming position)
//   data     : 11-bit message, corrected when a single error was found
//   flag     : FLG_NONE / FLG_SINGLE / FLG_DOUBLE
//   syndrome : XOR of the positions of all set bits 1..15
// -----------------------------------------------------------------------------
module secded_decode_core
    import hamming_pkg::*;
(
    input  logic [15:0] word,
    output logic [10:0] data,
    output flag_t       flag,
    output logic [3:0]  syndrome
);

    logic        parity;
    logic [15:0] fixed;

    // NOTE: every output of this block gets a default before any branch;
    // otherwise a path that skips an assignment would infer a latch.
    always_comb begin
        syndrome = 4'h0;
        for (int i = 1; i < 16; i++) begin
            if (word[i]) syndrome = syndrome ^ 4'(i);
        end
        parity = ^word;
        fixed  = word;
        flag   = FLG_NONE;
        if (parity) begin
            // Odd overall parity: exactly one bit flipped, at position
            // syndrome (syndrome 0 means P0 itself).
            fixed = word ^ (16'h0001 << syndrome);
            flag  = FLG_SINGLE;
        end else if (syndrome != 4'h0) begin
            flag = FLG_DOUBLE;
        end
        data = extract_data(fixed);
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder
// Memory-mastering accelerator: reads NUM_WORDS Hamming(16,11) SECDED words
// from SRC_BASE, decodes/corrects each, and writes the 11-bit message plus a
// 2-bit flag to DST_BASE. Five cycles per word: RD_LO, RD_HI, DECODE, WR_LO,
// WR_HI.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : hamming_secded_decoder_if.master (req/done, memory, statistics)
// Optional feature macro HAMMING_DEC_STATS_EN: when defined, err1_cnt/err2_cnt
// are saturating 4-bit counters; otherwise both ports are tied to 0.
// -----------------------------------------------------------------------------
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int NUM_WORDS = 15,
    parameter int AW        = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    hamming_secded_decoder_if.master        bus
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_t        state, next_state;
    logic [IW-1:0] index;
    logic [15:0]   word_q;
    logic [10:0]   data_q;
    flag_t         flag_q;

    logic [10:0]   dec_data;
    flag_t         dec_flag;
    logic [3:0]    unused_syndrome;

    logic          last_word;
    logic          start;
    logic [AW-1:0] src_lo;
    logic [AW-1:0] dst_lo;

    secded_decode_core u_core (
        .word     (word_q),
        .data     (dec_data),
        .flag     (dec_flag),
        .syndrome (unused_syndrome)
    );

    assign last_word = (index == IW'(NUM_WORDS - 1));
    assign start     = ((state == IDLE) || (state == DONE)) && bus.req;
    assign src_lo    = AW'(SRC_BASE) + AW'({index, 1'b0});
    assign dst_lo    = AW'(DST_BASE) + AW'({index, 1'b0});

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            index  <= '0;
            word_q <= '0;
            data_q <= '0;
            flag_q <= FLG_NONE;
        end else begin
            state <= next_state;
            case (state)
                IDLE, DONE: if (bus.req) index <= '0;
                RD_LO:      word_q[7:0]  <= bus.mem_rdata;
                RD_HI:      word_q[15:8] <= bus.mem_rdata;
                DECODE: begin
                    data_q <= dec_data;
                    flag_q <= dec_flag;
                end
                WR_HI:      if (!last_word) index <= index + IW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state    = state;
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'h00;
        bus.mem_we    = 1'b0;
        case (state)
            IDLE:   if (bus.req) next_state = RD_LO;
            RD_LO: begin
                bus.mem_addr = src_lo;
                next_state   = RD_HI;
            end
            RD_HI: begin
                bus.mem_addr = src_lo + AW'(1);
                next_state   = DECODE;
            end
            DECODE: next_state = WR_LO;
            WR_LO: begin
                bus.mem_addr  = dst_lo;
                bus.mem_wdata = data_q[7:0];
                bus.mem_we    = 1'b1;
                next_state    = WR_HI;
            end
            WR_HI: begin
                bus.mem_addr  = dst_lo + AW'(1);
                bus.mem_wdata = {flag_q, 3'b000, data_q[10:8]};
                bus.mem_we    = 1'b1;
                next_state    = last_word ? DONE : RD_LO;
            end
            DONE:   if (bus.req) next_state = RD_LO;
            default: next_state = IDLE;
        endcase
    end

    assign bus.done = (state == DONE);

`ifdef HAMMING_DEC_STATS_EN
    logic [3:0] err1_q, err2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err1_q <= 4'h0;
            err2_q <= 4'h0;
        end else if (start) begin
            err1_q <= 4'h0;
            err2_q <= 4'h0;
        end else if (state == DECODE) begin
            if ((dec_flag == FLG_SINGLE) && (err1_q != 4'hF)) err1_q <= err1_q + 4'h1;
            if ((dec_flag == FLG_DOUBLE) && (err2_q != 4'hF)) err2_q <= err2_q + 4'h1;
        end
    end

    assign bus.err1_cnt = err1_q;
    assign bus.err2_cnt = err2_q;
`else
    logic unused_start;
    assign unused_start = start;
    assign bus.err1_cnt = 4'h0;
    assign bus.err2_cnt = 4'h0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_decoder
// Self-checking bench for hamming_secded_decoder. The reference model encodes
// messages from the parity definitions and classifies received words by
// searching for the nearest valid codeword (distance 0, 1, or more).
// Honors HAMMING_DEC_STATS_EN for the expected counter values.
// -----------------------------------------------------------------------------
module tb_hamming_secded_decoder;

    localparam int SRC = 30;
    localparam int DST = 0;
    localparam int NW  = 15;
    localparam int AW  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hamming_secded_decoder_if #(.AW(AW)) bus ();

    hamming_secded_decoder #(
        .SRC_BASE  (SRC),
        .DST_BASE  (DST),
        .NUM_WORDS (NW),
        .AW        (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    int         we_total = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            we_total          <= we_total + 1;
        end
    end

    int          tests = 0;
    int          fails = 0;
    logic [15:0] enc_in  [NW];
    logic [15:0] exp_out [NW];
    int          exp_e1, exp_e2;

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_encode(input logic [10:0] d);
        logic [15:0] w;
        int          k;
        logic        par;
        w = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> b) & 1) == 1) par = par ^ w[pos];
            w[1 << b] = par;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] ref_extract(input logic [15:0] w);
        logic [10:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = w[pos];
                k++;
            end
        end
        return d;
    endfunction

    // kind: 0 clean, 1 corrected single, 2 uncorrectable double
    function automatic void ref_decode(input logic [15:0] w,
                                       output logic [15:0] out, output int kind);
        logic [15:0] c;
        logic [10:0] d;
        kind = 2;
        d    = ref_extract(w);
        if (ref_encode(ref_extract(w)) == w) begin
            kind = 0;
        end else begin
            for (int j = 0; j < 16; j++) begin
                c = w ^ (16'h0001 << j);
                if (kind == 2 && ref_encode(ref_extract(c)) == c) begin
                    kind = 1;
                    d    = ref_extract(c);
                end
            end
        end
        out = {2'(kind), 3'b000, d};
    endfunction

    // Loads enc_in into source memory, fills destination with 0xEE and
    // builds the expected outputs and counts.
    task automatic prepare_job();
        int kind;
        exp_e1 = 0;
        exp_e2 = 0;
        for (int i = 0; i < NW; i++) begin
            mem[SRC + 2*i]     = enc_in[i][7:0];
            mem[SRC + 2*i + 1] = enc_in[i][15:8];
            mem[DST + 2*i]     = 8'hEE;
            mem[DST + 2*i + 1] = 8'hEE;
            ref_decode(enc_in[i], exp_out[i], kind);
            if (kind == 1 && exp_e1 < 15) exp_e1++;
            if (kind == 2 && exp_e2 < 15) exp_e2++;
        end
`ifndef HAMMING_DEC_STATS_EN
        exp_e1 = 0;
        exp_e2 = 0;
`endif
    endtask

    function automatic logic [15:0] random_word();
        logic [15:0] w;
        int          n, a, b;
        w = ref_encode(11'($urandom));
        n = $urandom_range(0, 2);
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        if (n >= 1) w[a] = ~w[a];
        if (n == 2) w[b] = ~w[b];
        return w;
    endfunction

    // Raises req for one edge and counts rising edges (that edge included)
    // until done is seen high, bounded at 200 edges.
    task automatic run_job(output int edges, output logic done_after_start);
        @(negedge clk);
        bus.req = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        bus.req = 1'b0;
        done_after_start = bus.done;
        while (bus.done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset   = 1'b0;
        bus.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.done !== 1'b0)     begin fails++; $display("FAIL reset_done got %b exp 0", bus.done); end
        tests++; if (bus.mem_we !== 1'b0)   begin fails++; $display("FAIL reset_we got %b exp 0", bus.mem_we); end
        tests++; if (bus.mem_addr !== 8'h0) begin fails++; $display("FAIL reset_addr got %h exp 00", bus.mem_addr); end
        tests++; if (bus.mem_wdata !== 8'h0) begin fails++; $display("FAIL reset_wdata got %h exp 00", bus.mem_wdata); end
        tests++; if (bus.err1_cnt !== 4'h0) begin fails++; $display("FAIL reset_err1 got %h exp 0", bus.err1_cnt); end
        tests++; if (bus.err2_cnt !== 4'h0) begin fails++; $display("FAIL reset_err2 got %h exp 0", bus.err2_cnt); end
        @(negedge clk);
        reset = 1'b1;
        // req ignored-free IDLE: with req low the decoder must stay idle.
        repeat (4) @(posedge clk);
        #1;
        tests++; if (bus.mem_we !== 1'b0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL idle_quiet we=%b done=%b exp 0/0", bus.mem_we, bus.done);
        end
    endtask

    task automatic test_directed();
        int          edges;
        logic        d0;
        logic [15:0] got;
        logic [15:0] want [4];
        want[0] = 16'h0555;
        want[1] = 16'h4555;
        want[2] = 16'h4555;
        want[3] = 16'h8551;
        enc_in[0] = 16'hAA5A;
        enc_in[1] = 16'hAA1A;
        enc_in[2] = 16'hAA5B;
        enc_in[3] = 16'hAA18;
        for (int i = 4; i < NW; i++) enc_in[i] = ref_encode(11'($urandom));
        prepare_job();
        run_job(edges, d0);
        for (int i = 0; i < NW; i++) begin
            got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
            tests++;
            if (i < 4) begin
                if (got !== want[i]) begin fails++; $display("FAIL directed_word%0d got %h exp %h", i, got, want[i]); end
            end else if (got !== exp_out[i]) begin
                fails++; $display("FAIL directed_word%0d got %h exp %h", i, got, exp_out[i]);
            end
        end
`ifdef HAMMING_DEC_STATS_EN
        tests++; if (bus.err1_cnt !== 4'd2) begin fails++; $display("FAIL directed_err1 got %0d exp 2", bus.err1_cnt); end
        tests++; if (bus.err2_cnt !== 4'd1) begin fails++; $display("FAIL directed_err2 got %0d exp 1", bus.err2_cnt); end
`else
        tests++; if (bus.err1_cnt !== 4'd0 || bus.err2_cnt !== 4'd0) begin
            fails++; $display("FAIL directed_cnt_tied got %0d/%0d exp 0/0", bus.err1_cnt, bus.err2_cnt);
        end
`endif
    endtask

    task automatic test_random_job();
        int          edges, w0;
        logic        d0;
        logic [15:0] got;
        for (int i = 0; i < NW; i++) enc_in[i] = random_word();
        prepare_job();
        // Start from DONE of the previous job.
        w0 = we_total;
        run_job(edges, d0);
        tests++; if (d0 !== 1'b0) begin fails++; $display("FAIL done_drop got %b exp 0", d0); end
        tests++; if (edges != 5*NW + 1) begin fails++; $display("FAIL done_latency got %0d exp %0d", edges, 5*NW + 1); end
        tests++; if (we_total - w0 != 2*NW) begin fails++; $display("FAIL we_pulses got %0d exp %0d", we_total - w0, 2*NW); end
        for (int i = 0; i < NW; i++) begin
            got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
            tests++; if (got !== exp_out[i]) begin fails++; $display("FAIL random_word%0d in %h got %h exp %h", i, enc_in[i], got, exp_out[i]); end
        end
        tests++; if (bus.err1_cnt !== 4'(exp_e1)) begin fails++; $display("FAIL random_err1 got %0d exp %0d", bus.err1_cnt, exp_e1); end
        tests++; if (bus.err2_cnt !== 4'(exp_e2)) begin fails++; $display("FAIL random_err2 got %0d exp %0d", bus.err2_cnt, exp_e2); end
        // done holds in DONE while req stays low.
        repeat (5) @(posedge clk);
        #1;
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL done_hold got %b exp 1", bus.done); end
    endtask

    task automatic test_back_to_back();
        int          edges, w0;
        logic        d0;
        logic [15:0] got;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NW; i++) enc_in[i] = random_word();
            prepare_job();
            w0 = we_total;
            run_job(edges, d0);
            tests++; if (edges != 5*NW + 1 || we_total - w0 != 2*NW) begin
                fails++; $display("FAIL b2b%0d_timing edges %0d writes %0d exp %0d/%0d", r, edges, we_total - w0, 5*NW + 1, 2*NW);
            end
            for (int i = 0; i < NW; i++) begin
                got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
                tests++; if (got !== exp_out[i]) begin fails++; $display("FAIL b2b%0d_word%0d got %h exp %h", r, i, got, exp_out[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int          edges, w0;
        logic        d0;
        logic [15:0] got;
        for (int i = 0; i < NW; i++) enc_in[i] = random_word();
        prepare_job();
        @(negedge clk);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        tests++; if (bus.mem_addr !== 8'(SRC + 7)) begin fails++; $display("FAIL mid_rdhi_addr got %h exp %h", bus.mem_addr, 8'(SRC + 7)); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tests++; if (bus.done !== 1'b0 || bus.mem_we !== 1'b0) begin
            fails++; $display("FAIL mid_reset_out done=%b we=%b exp 0/0", bus.done, bus.mem_we);
        end
        tests++; if (bus.err1_cnt !== 4'h0 || bus.err2_cnt !== 4'h0) begin
            fails++; $display("FAIL mid_reset_cnt got %0d/%0d exp 0/0", bus.err1_cnt, bus.err2_cnt);
        end
        w0 = we_total;
        repeat (20) @(posedge clk);
        #1;
        tests++; if (we_total != w0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL mid_quiet writes %0d done=%b exp 0/0", we_total - w0, bus.done);
        end
        for (int i = 0; i < NW; i++) begin
            got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
            tests++;
            if (i < 3) begin
                if (got !== exp_out[i]) begin fails++; $display("FAIL mid_kept_word%0d got %h exp %h", i, got, exp_out[i]); end
            end else if (got !== 16'hEEEE) begin
                fails++; $display("FAIL mid_untouched_word%0d got %h exp eeee", i, got);
            end
        end
        run_job(edges, d0);
        tests++; if (edges != 5*NW + 1) begin fails++; $display("FAIL rerun_latency got %0d exp %0d", edges, 5*NW + 1); end
        for (int i = 0; i < NW; i++) begin
            got = {mem[DST + 2*i + 1], mem[DST + 2*i]};
            tests++; if (got !== exp_out[i]) begin fails++; $display("FAIL rerun_word%0d got %h exp %h", i, got, exp_out[i]); end
        end
        tests++; if (bus.err1_cnt !== 4'(exp_e1) || bus.err2_cnt !== 4'(exp_e2)) begin
            fails++; $display("FAIL rerun_cnt got %0d/%0d exp %0d/%0d", bus.err1_cnt, bus.err2_cnt, exp_e1, exp_e2);
        end
    endtask

    initial begin
        bus.req = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        test_reset();
        test_directed();
        test_random_job();
        test_back_to_back();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Program-2 datapath engine that reverses the Hamming(16,11) SECDED encoding produced by program 1. It walks NUM_WORDS encoded 16-bit words in data memory, computes the syndrome and overall parity for each, and corrects any single-bit error. It writes each 11-bit message back with a 2-bit error flag. It sits beside the core as a memory-mastering accelerator and uses the same req/done handshake as top_level.

## Interface
- SRC_BASE, 30: byte address of word 0's low byte (encoded input).
- DST_BASE, 0: byte address of word 0's low byte (decoded output).
- NUM_WORDS, 15: number of words processed per request.
- AW, 8: memory byte-address width.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising clk.
- req  input  1  start request, level-sampled in IDLE.
- done  output  1  job complete, level.
- mem_addr  output  AW  byte address for read or write.
- mem_rdata  input  8  read data, combinational from mem_addr (same cycle).
- mem_wdata  output  8  write data.
- mem_we  output  1  write strobe; memory writes on the rising edge where it is high.
- err1_cnt  output  4  count of corrected single-error words in the last job.
- err2_cnt  output  4  count of detected double-error words in the last job.

## Operation
- Encoded word layout, bit15..0: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}. Bit index equals Hamming position; p0 is overall parity.
- Input word i: low byte at SRC_BASE+2i, high byte at SRC_BASE+2i+1.
- Output word i: low byte at DST_BASE+2i = d8..d1; high byte at DST_BASE+2i+1 = {F1,F0,3'b000,d11..d9}.
- Syndrome s[3:0] = XOR of the indices of all set bits 1..15. Overall parity P = XOR of all 16 bits.
- Decode cases:
  - s==0, P==0: no error, F=00.
  - P==1: single error at position s (s==0 means p0 flipped); flip that bit, then extract data; F=01.
  - s!=0, P==0: double error; extract data uncorrected; F=10.
  - F=11 is never produced.
- FSM states: IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE.
  - IDLE → RD_LO on req=1; this clears the word index and both counters.
  - RD_LO → RD_HI → DECODE → WR_LO → WR_HI.
  - WR_HI → RD_LO with index+1 if index<NUM_WORDS-1, else DONE.
  - DONE → RD_LO on req=1 (new job), else stay in DONE.
- Counters saturate at 4'hF; they increment in DECODE.
- req is ignored in every state except IDLE and DONE.

## Timing
- Reset (reset=0 at a rising edge): state=IDLE, done=0, mem_we=0, mem_addr=0, mem_wdata=0, err1_cnt=0, err2_cnt=0, index=0.
- Reset mid-job aborts on that edge. Bytes already written stay; no further writes occur.
- Each word takes 5 cycles. From the first rising edge with req=1 in IDLE, done rises 5*NUM_WORDS+1 edges later (76 for defaults).
- mem_we is high only in WR_LO and WR_HI, exactly one cycle each; mem_addr and mem_wdata are stable in those cycles.
- RD_LO and RD_HI drive mem_addr and capture mem_rdata at the end of the cycle.
- done stays high in DONE until a new req or reset. It drops on the edge that leaves DONE.
- SRC and DST regions are assumed disjoint; overlap behaviour is undefined.

## Configuration
- HAMMING_DEC_STATS_EN:
  - Defined: err1_cnt and err2_cnt count as described.
  - Undefined: counter registers are not built, and both ports are tied to 4'h0.
  - Decode and memory behaviour are identical either way.

## Structure
- hamming_pkg holds:
  - state_t enum.
  - flag_t enum: FLG_NONE=2'b00, FLG_SINGLE=2'b01, FLG_DOUBLE=2'b10.
  - Bit-position localparams P0_POS=0, P1_POS=1, P2_POS=2, P4_POS=4, P8_POS=8.
  - function extract_data(16b) → 11b.
- One sub-module, secded_decode_core: combinational, 16-bit word in → 11-bit data, flag_t, syndrome out. The FSM and address generation stay in the top.

## Test plan
- Clean word: input 0xAA5A → output 0x0555; err1_cnt=0, err2_cnt=0.
- Single data error, bit 6 flipped: 0xAA1A → 0x4555, err1_cnt=1.
- Overall-parity-only error: 0xAA5B → 0x4555.
- Double error, bits 6 and 1 flipped: 0xAA18 → 0x8551, err2_cnt=1.
- Full 15-word random run (mix of 0/1/2 flips) matches the reference model. done rises exactly 76 cycles after req, and mem_we pulses exactly 30 times.
- Reset mid-job: assert reset=0 during word 3's RD_HI. Then done=0, no further writes, output bytes for words 3..14 are untouched, and a following req reruns the job correctly.
